// File: rtl/uart_pkg.sv
// Shared UART definitions: default framing and timing constants and the receiver phase type.
// The transmitter imports this package as well.
package uart_pkg;

    localparam int unsigned INPUT_DATA_WIDTH           = 8;
    localparam int unsigned CLOCKS_PER_BIT             = 8;
    localparam int unsigned NUMBER_OF_RX_SYNCHRONIZERS = 3;
    localparam int unsigned NUMBER_OF_BITS             = INPUT_DATA_WIDTH + 3;

    typedef enum logic [2:0] {
        Rx_IDLE,
        Rx_START_BIT,
        Rx_DATA_BIT,
        Rx_PARITY_BIT,
        Rx_STOP_BIT
    } rx_phase_e;

    // Flat state code: IDLE=0, START=1, DATA_k=2+k, PARITY=W+2, STOP=W+3.
    function automatic int unsigned rx_state_code(input rx_phase_e   phase,
                                                  input int unsigned bit_idx,
                                                  input int unsigned width);
        int unsigned code;
        case (phase)
            Rx_IDLE:       code = 0;
            Rx_START_BIT:  code = 1;
            Rx_DATA_BIT:   code = 2 + bit_idx;
            Rx_PARITY_BIT: code = width + 2;
            default:       code = width + 3;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/uart_rx_synchronizer.sv
// N-stage flop chain for bringing an asynchronous level into the clk domain.
// Flops reset to 1 so an idle-high line does not look like an edge after reset.
module uart_rx_synchronizer #(
    parameter int unsigned Stages = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic [Stages-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= async_i;
            for (int unsigned i = 1; i < Stages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_o = sync_q[Stages-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver for start + data (LSB first) + even parity + stop frames.
// Emits one-cycle data_is_valid / rx_error strobes when the stop bit is sampled.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned INPUT_DATA_WIDTH           = uart_pkg::INPUT_DATA_WIDTH,
    parameter int unsigned CLOCKS_PER_BIT             = uart_pkg::CLOCKS_PER_BIT,
    parameter int unsigned NUMBER_OF_RX_SYNCHRONIZERS = uart_pkg::NUMBER_OF_RX_SYNCHRONIZERS
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     serial_in,
    output logic [INPUT_DATA_WIDTH-1:0]              received_data,
    output logic                                     data_is_valid,
    output logic                                     rx_error,
    output logic                                     o_busy,
    output logic [$clog2(INPUT_DATA_WIDTH+3)-1:0]    state
);

    localparam int unsigned W  = INPUT_DATA_WIDTH;
    localparam int unsigned SW = $clog2(W + 3);
    localparam int unsigned CW = $clog2(CLOCKS_PER_BIT);
    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

    localparam logic [CW-1:0] HalfBit = CW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FullBit = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [IW-1:0] LastIdx = IW'(W - 1);

    logic rx_s;

    rx_phase_e     phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [W-1:0]  data_q, data_d;
    logic          parity_err_q, parity_err_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    uart_rx_synchronizer #(
        .Stages(NUMBER_OF_RX_SYNCHRONIZERS)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .async_i(serial_in),
        .sync_o (rx_s)
    );

    always_comb begin
        phase_d      = phase_q;
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        parity_err_d = parity_err_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;

        unique case (phase_q)
            Rx_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) phase_d = Rx_START_BIT;
            end
            Rx_START_BIT: begin
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (cnt_q == HalfBit) begin
                    cnt_d   = '0;
                    phase_d = rx_s ? Rx_IDLE : Rx_DATA_BIT;
                end
            end
            Rx_DATA_BIT: begin
                if (cnt_q == FullBit) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == LastIdx) phase_d = Rx_PARITY_BIT;
                    else                  idx_d   = idx_q + 1'b1;
                end
            end
            Rx_PARITY_BIT: begin
                if (cnt_q == FullBit) begin
                    cnt_d        = '0;
                    parity_err_d = rx_s ^ (^shift_q);
                    phase_d      = Rx_STOP_BIT;
                end
            end
            Rx_STOP_BIT: begin
                // Leaving at mid-stop re-arms IDLE in time for a back-to-back start edge.
                if (cnt_q == FullBit) begin
                    cnt_d   = '0;
                    phase_d = Rx_IDLE;
                    if (rx_s && !parity_err_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: phase_d = Rx_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_q      <= Rx_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            parity_err_q <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            parity_err_q <= parity_err_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
        end
    end

    assign received_data = data_q;
    assign data_is_valid = valid_q;
    assign rx_error      = err_q;
    assign o_busy        = (phase_q != Rx_IDLE);
    assign state         = SW'(rx_state_code(phase_q, 32'(idx_q), W));

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: frames are built from bit-level rules,
// expected strobes (kind, data, arrival cycle) are queued and checked by a separate monitor.
module tb_uart_rx;

    localparam int unsigned W    = 8;
    localparam int unsigned CPB  = 8;
    localparam int unsigned SYNC = 3;
    // Strobe lands (W+3)*CPB cycles after the start edge is driven onto serial_in.
    localparam int unsigned FrameCycles = (W + 3) * CPB;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         serial_in = 1'b1;
    logic [W-1:0] received_data;
    logic         data_is_valid;
    logic         rx_error;
    logic         o_busy;
    logic [3:0]   state;

    uart_rx #(
        .INPUT_DATA_WIDTH          (W),
        .CLOCKS_PER_BIT            (CPB),
        .NUMBER_OF_RX_SYNCHRONIZERS(SYNC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .received_data(received_data),
        .data_is_valid(data_is_valid),
        .rx_error     (rx_error),
        .o_busy       (o_busy),
        .state        (state)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit           err;
        logic [W-1:0] data;
        int unsigned  cycle;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] last_good = '0;
    int           n_checks = 0;
    int           n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one full frame; the expected outcome is queued before the first bit goes out.
    task automatic drive_frame(input logic [W-1:0] d, input bit par_flip, input bit stop_val);
        bit par;
        bit good;
        par  = (^d) ^ par_flip;
        good = stop_val && !par_flip;
        if (good) last_good = d;
        exp_q.push_back('{err: !good, data: last_good, cycle: cyc + FrameCycles});
        serial_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < int'(W); i++) begin
            serial_in = d[i];
            tick(CPB);
        end
        serial_in = par;
        tick(CPB);
        serial_in = stop_val;
        tick(CPB);
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && (data_is_valid || rx_error)) begin
                check("no_dual_strobe", 32'(data_is_valid & rx_error), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind_err", 32'(rx_error), 32'(e.err));
                    check("received_data", 32'(received_data), 32'(e.data));
                    check("strobe_cycle", cyc, e.cycle);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] d;
        bit           pf;
        bit           sv;
        int unsigned  gap;

        // Reset values
        tick(3);
        check("rst_state", 32'(state), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_valid", 32'(data_is_valid), 32'd0);
        check("rst_err", 32'(rx_error), 32'd0);
        check("rst_data", 32'(received_data), 32'd0);
        reset = 1'b1;
        tick(4);

        // Good 0xA5, then 0xA5 with wrong parity (data must hold 0xA5)
        drive_frame(8'hA5, 1'b0, 1'b1);
        tick(2 * CPB);
        drive_frame(8'hA5, 1'b1, 1'b1);
        tick(2 * CPB);

        // Glitch: two low cycles on an idle line -> brief START, then IDLE
        serial_in = 1'b0;
        tick(2);
        serial_in = 1'b1;
        tick(2);
        check("glitch_start_state", 32'(state), 32'd1);
        check("glitch_busy_high", 32'(o_busy), 32'd1);
        tick(4);
        check("glitch_idle_state", 32'(state), 32'd0);
        check("glitch_busy_low", 32'(o_busy), 32'd0);
        tick(2 * CPB);

        // Break: 0x3C with stop low, line held low -> error, then START again
        drive_frame(8'h3C, 1'b0, 1'b0);
        tick(1);
        check("break_restart_state", 32'(state), 32'd1);
        check("break_busy", 32'(o_busy), 32'd1);
        tick(CPB);
        reset = 1'b0;
        serial_in = 1'b1;
        tick(2);
        last_good = '0;
        reset = 1'b1;
        tick(2 * CPB);

        // Reset during DATA_4 of 0xFF; frame is dropped silently
        drive_frame(8'h5A, 1'b0, 1'b1);
        serial_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            serial_in = 1'b1;
            tick(CPB);
        end
        serial_in = 1'b1;
        tick(2);
        check("mid_frame_state_data4", 32'(state), 32'd6);
        reset = 1'b0;
        tick(1);
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_valid", 32'(data_is_valid), 32'd0);
        check("mid_rst_err", 32'(rx_error), 32'd0);
        check("mid_rst_data", 32'(received_data), 32'd0);
        last_good = '0;
        reset = 1'b1;
        tick(2 * CPB);
        drive_frame(8'h81, 1'b0, 1'b1);
        tick(CPB);

        // Back-to-back, no idle gap
        drive_frame(8'h00, 1'b0, 1'b1);
        drive_frame(8'hFF, 1'b0, 1'b1);
        drive_frame(8'h55, 1'b0, 1'b1);

        // Random frames with occasional parity/stop faults and random gaps
        for (int n = 0; n < 30; n++) begin
            d   = W'($urandom);
            pf  = ($urandom_range(0, 3) == 0);
            sv  = ($urandom_range(0, 7) != 0);
            gap = $urandom_range(0, 2 * CPB);
            drive_frame(d, pf, sv);
            serial_in = 1'b1;
            if (!sv && gap < CPB) gap = CPB;
            if (gap > 0) tick(gap);
        end

        for (int i = 0; i < 500 && exp_q.size() != 0; i++) tick(1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
